// File: rtl/ref_force_wb_arbiter.sv
// Reference-force writeback arbiter: per-accumulator FIFOs, round-robin serialization onto one
// valid/ready writeback port, and end-of-iteration flush sequencing.
module ref_force_wb_arbiter #(
   parameter int DATA_WIDTH        = 32,
   parameter int PARTICLE_ID_WIDTH = 20,
   parameter int CELL_ID_WIDTH     = 3,
   parameter int ID_WIDTH          = 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH,
   parameter int NUM_ACC           = 7,
   parameter int FIFO_DEPTH        = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_ACC-1:0]               in_acc_valid,
   input  logic [NUM_ACC*ID_WIDTH-1:0]      in_acc_id,
   input  logic [NUM_ACC*DATA_WIDTH-1:0]    in_acc_force_x,
   input  logic [NUM_ACC*DATA_WIDTH-1:0]    in_acc_force_y,
   input  logic [NUM_ACC*DATA_WIDTH-1:0]    in_acc_force_z,
   input  logic                             in_flush,
   input  logic                             out_wb_ready,
   output logic                             out_wb_valid,
   output logic [ID_WIDTH-1:0]              out_wb_id,
   output logic [DATA_WIDTH-1:0]            out_wb_force_x,
   output logic [DATA_WIDTH-1:0]            out_wb_force_y,
   output logic [DATA_WIDTH-1:0]            out_wb_force_z,
   output logic [2:0]                       out_wb_src,
   output logic                             out_flush_done,
   output logic                             out_busy,
   output logic [NUM_ACC-1:0]               err_overflow
);

   localparam int ENTRY_W = ID_WIDTH + 3*DATA_WIDTH;
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CW      = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   logic [ENTRY_W-1:0] mem_r      [NUM_ACC][FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr_r   [NUM_ACC];
   logic [AW-1:0]      rd_ptr_r   [NUM_ACC];
   logic [CW-1:0]      count_r    [NUM_ACC];
   logic [ENTRY_W-1:0] in_entry_s [NUM_ACC];
   logic [NUM_ACC-1:0] nonempty_s, full_s, push_s, pop_s, accept_s, ovf_s;
   logic [2:0]         rr_ptr_r, grant_idx_s, idx_s;
   logic               grant_vld_s, load_s;
   logic [ENTRY_W-1:0] head_s;
   state_t             state_r, state_next_s;
   logic               flush_done_r;

   // Per-source FIFO status and incoming entry packing; all-+0 force triples never enter a FIFO.
   always_comb begin
      for (int i = 0; i < NUM_ACC; i++) begin
         in_entry_s[i] = {in_acc_id[i*ID_WIDTH +: ID_WIDTH],
                          in_acc_force_x[i*DATA_WIDTH +: DATA_WIDTH],
                          in_acc_force_y[i*DATA_WIDTH +: DATA_WIDTH],
                          in_acc_force_z[i*DATA_WIDTH +: DATA_WIDTH]};
         nonempty_s[i] = (count_r[i] != {CW{1'b0}});
         full_s[i]     = (count_r[i] == CW'(FIFO_DEPTH));
         push_s[i]     = in_acc_valid[i] & (in_entry_s[i][3*DATA_WIDTH-1:0] != {(3*DATA_WIDTH){1'b0}});
      end
   end

   // Round-robin search starting one past the last granted source.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_idx_s = 3'd0;
      idx_s       = 3'd0;
      for (int k = 1; k <= NUM_ACC; k++) begin
         idx_s = 3'((int'(rr_ptr_r) + k) % NUM_ACC);
         if (!grant_vld_s && nonempty_s[idx_s]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = idx_s;
         end else begin
            grant_vld_s = grant_vld_s;
         end
      end
      head_s = mem_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
   end

   // A pop frees the slot in the same cycle, so a push to a full FIFO being popped still lands.
   always_comb begin
      load_s = ~out_wb_valid | out_wb_ready;
      for (int i = 0; i < NUM_ACC; i++) begin
         pop_s[i]    = load_s & grant_vld_s & (grant_idx_s == 3'(i));
         accept_s[i] = push_s[i] & (~full_s[i] | pop_s[i]);
         ovf_s[i]    = push_s[i] & full_s[i] & ~pop_s[i];
      end
   end

   // FIFO storage (data only, no reset needed).
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_ACC; i++) begin
         if (accept_s[i]) begin
            mem_r[i][wr_ptr_r[i]] <= in_entry_s[i];
         end
      end
   end

   // FIFO pointers, occupancy and sticky overflow flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ACC; i++) begin
            wr_ptr_r[i] <= {AW{1'b0}};
            rd_ptr_r[i] <= {AW{1'b0}};
            count_r[i]  <= {CW{1'b0}};
         end
         err_overflow <= {NUM_ACC{1'b0}};
      end else begin
         for (int i = 0; i < NUM_ACC; i++) begin
            if (accept_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + AW'(1);
            if (pop_s[i])    rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1);
            case ({accept_s[i], pop_s[i]})
               2'b10:   count_r[i] <= count_r[i] + CW'(1);
               2'b01:   count_r[i] <= count_r[i] - CW'(1);
               default: count_r[i] <= count_r[i];
            endcase
         end
         err_overflow <= err_overflow | ovf_s;
      end
   end

   // Output register; it only changes on a load, so a stalled word holds steady.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_wb_valid   <= 1'b0;
         out_wb_id      <= {ID_WIDTH{1'b0}};
         out_wb_force_x <= {DATA_WIDTH{1'b0}};
         out_wb_force_y <= {DATA_WIDTH{1'b0}};
         out_wb_force_z <= {DATA_WIDTH{1'b0}};
         out_wb_src     <= 3'd0;
         rr_ptr_r       <= 3'(NUM_ACC-1);
      end else if (load_s) begin
         out_wb_valid <= grant_vld_s;
         if (grant_vld_s) begin
            out_wb_id      <= head_s[ENTRY_W-1 -: ID_WIDTH];
            out_wb_force_x <= head_s[3*DATA_WIDTH-1 -: DATA_WIDTH];
            out_wb_force_y <= head_s[2*DATA_WIDTH-1 -: DATA_WIDTH];
            out_wb_force_z <= head_s[DATA_WIDTH-1:0];
            out_wb_src     <= grant_idx_s;
            rr_ptr_r       <= grant_idx_s;
         end
      end
   end

   // Flush sequencing; an IDLE flush with leftover data drains through FLUSH rather than finishing at once.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (in_flush) begin
               state_next_s = (|nonempty_s | out_wb_valid | |accept_s) ? ST_FLUSH : ST_DONE;
            end else if (|accept_s) begin
               state_next_s = ST_ACTIVE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (in_flush) state_next_s = ST_FLUSH;
            else          state_next_s = ST_ACTIVE;
         end
         ST_FLUSH: begin
            if (!(|nonempty_s) && !out_wb_valid && !(|accept_s)) state_next_s = ST_DONE;
            else                                                 state_next_s = ST_FLUSH;
         end
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State register and the registered done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         flush_done_r <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         flush_done_r <= (state_next_s == ST_DONE);
      end
   end

   assign out_flush_done = flush_done_r;
   assign out_busy       = (|nonempty_s) | out_wb_valid;

endmodule

// File: tb/tb_ref_force_wb_arbiter.sv
// Directed self-checking bench for ref_force_wb_arbiter with immediate assertions at each check.
module tb_ref_force_wb_arbiter;

   localparam int NA = 7;
   localparam int IW = 29;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [NA-1:0]     in_acc_valid;
   logic [NA*IW-1:0]  in_acc_id;
   logic [NA*DW-1:0]  in_acc_force_x, in_acc_force_y, in_acc_force_z;
   logic              in_flush, out_wb_ready;
   logic              out_wb_valid;
   logic [IW-1:0]     out_wb_id;
   logic [DW-1:0]     out_wb_force_x, out_wb_force_y, out_wb_force_z;
   logic [2:0]        out_wb_src;
   logic              out_flush_done, out_busy;
   logic [NA-1:0]     err_overflow;

   int n_assert = 0;
   int n_fail   = 0;

   ref_force_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .in_acc_valid(in_acc_valid), .in_acc_id(in_acc_id),
      .in_acc_force_x(in_acc_force_x), .in_acc_force_y(in_acc_force_y), .in_acc_force_z(in_acc_force_z),
      .in_flush(in_flush), .out_wb_ready(out_wb_ready),
      .out_wb_valid(out_wb_valid), .out_wb_id(out_wb_id),
      .out_wb_force_x(out_wb_force_x), .out_wb_force_y(out_wb_force_y), .out_wb_force_z(out_wb_force_z),
      .out_wb_src(out_wb_src), .out_flush_done(out_flush_done), .out_busy(out_busy),
      .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [2:0] src, input logic [IW-1:0] id,
                           input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] z);
      chk(tag, {out_wb_valid, out_wb_src, out_wb_id, out_wb_force_x, out_wb_force_y, out_wb_force_z},
               {1'b1, src, id, x, y, z});
   endtask

   task automatic clear_in();
      in_acc_valid   = '0;
      in_acc_id      = '0;
      in_acc_force_x = '0;
      in_acc_force_y = '0;
      in_acc_force_z = '0;
      in_flush       = 1'b0;
   endtask

   task automatic drive(input int s, input logic [IW-1:0] id,
                        input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] z);
      in_acc_valid[s]           = 1'b1;
      in_acc_id[s*IW +: IW]     = id;
      in_acc_force_x[s*DW +: DW] = x;
      in_acc_force_y[s*DW +: DW] = y;
      in_acc_force_z[s*DW +: DW] = z;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      clear_in();
      out_wb_ready = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      chk("rst_word", {out_wb_valid, out_wb_src, out_wb_id, out_wb_force_x, out_wb_force_y, out_wb_force_z}, '0);
      chk("rst_flags", {out_flush_done, out_busy, err_overflow}, '0);
      rst = 1'b0;

      // 1: single source, latency
      drive(3, 29'h0A00005, 32'h3F80_0000, 32'h0, 32'h0);
      tick();
      clear_in();
      chk("t1_not_yet", {out_wb_valid, out_busy}, {1'b0, 1'b1});
      tick();
      chk_word("t1_word", 3'd3, 29'h0A00005, 32'h3F80_0000, 32'h0, 32'h0);
      tick();
      chk("t1_drained", {out_wb_valid, out_busy}, '0);

      // 2: all sources at once, two bursts, strict 0..6 order
      do_reset();
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < NA; i++)
            drive(i, 29'(32'h100 + 32'(b*16 + i)), 32'h3F80_0000 + 32'(i), 32'h4000_0000 + 32'(b), 32'h0);
         tick();
         clear_in();
         for (int i = 0; i < NA; i++) begin
            tick();
            chk_word("t2_burst", 3'(i), 29'(32'h100 + 32'(b*16 + i)), 32'h3F80_0000 + 32'(i),
                     32'h4000_0000 + 32'(b), 32'h0);
         end
         tick();
         chk("t2_idle", {out_wb_valid, out_busy}, '0);
      end

      // 3: back-pressure holds the word stable
      out_wb_ready = 1'b0;
      drive(1, 29'h11, 32'h1, 32'h2, 32'h3);
      drive(2, 29'h22, 32'h4, 32'h5, 32'h6);
      drive(4, 29'h44, 32'h7, 32'h8, 32'h9);
      tick();
      clear_in();
      tick();
      chk_word("t3_first", 3'd1, 29'h11, 32'h1, 32'h2, 32'h3);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk_word("t3_stall", 3'd1, 29'h11, 32'h1, 32'h2, 32'h3);
      end
      out_wb_ready = 1'b1;
      tick();
      chk_word("t3_second", 3'd2, 29'h22, 32'h4, 32'h5, 32'h6);
      tick();
      chk_word("t3_third", 3'd4, 29'h44, 32'h7, 32'h8, 32'h9);
      tick();
      chk("t3_empty", {out_wb_valid, out_busy}, '0);

      // 4: overflow on source 2 while the output register holds a source-0 word
      out_wb_ready = 1'b0;
      drive(0, 29'h200, 32'hAA, 32'h0, 32'h0);
      tick();
      clear_in();
      tick();
      for (int k = 0; k < 6; k++) begin
         drive(2, 29'(32'h300 + 32'(k)), 32'(k + 1), 32'h0, 32'h0);
         tick();
         clear_in();
         if (k == 3) chk("t4_no_ovf_yet", err_overflow, 7'b0000000);
      end
      chk("t4_ovf", err_overflow, 7'b0000100);
      chk_word("t4_held", 3'd0, 29'h200, 32'hAA, 32'h0, 32'h0);
      out_wb_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_word("t4_drain", 3'd2, 29'(32'h300 + 32'(k)), 32'(k + 1), 32'h0, 32'h0);
      end
      tick();
      chk("t4_dropped", {out_wb_valid, out_busy, err_overflow}, {1'b0, 1'b0, 7'b0000100});

      // 5: +0 triple filtered, -0 kept; IDLE flush gives an immediate done pulse
      do_reset();
      drive(1, 29'h55, 32'h0, 32'h0, 32'h0);
      tick();
      clear_in();
      chk("t5_zero_busy", out_busy, 1'b0);
      tick();
      chk("t5_zero_valid", out_wb_valid, 1'b0);
      in_flush = 1'b1;
      tick();
      in_flush = 1'b0;
      chk("t5_idle_done", out_flush_done, 1'b1);
      tick();
      chk("t5_done_pulse", out_flush_done, 1'b0);
      drive(1, 29'h56, 32'h8000_0000, 32'h0, 32'h0);
      tick();
      clear_in();
      tick();
      chk_word("t5_neg_zero", 3'd1, 29'h56, 32'h8000_0000, 32'h0, 32'h0);

      // 6: flush drains four words then pulses done
      do_reset();
      for (int i = 0; i < 4; i++) drive(i, 29'(32'h400 + 32'(i)), 32'h10 + 32'(i), 32'h0, 32'h1);
      tick();
      clear_in();
      in_flush = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         in_flush = 1'b0;
         chk_word("t6_drain", 3'(i), 29'(32'h400 + 32'(i)), 32'h10 + 32'(i), 32'h0, 32'h1);
         chk("t6_no_done", out_flush_done, 1'b0);
      end
      tick();
      chk("t6_empty", {out_wb_valid, out_busy, out_flush_done}, 3'b000);
      tick();
      chk("t6_done", out_flush_done, 1'b1);
      tick();
      chk("t6_done_once", out_flush_done, 1'b0);

      // reset in the middle of a drain discards everything
      for (int i = 0; i < 4; i++) drive(i, 29'(32'h500 + 32'(i)), 32'h20, 32'h0, 32'h0);
      tick();
      clear_in();
      in_flush = 1'b1;
      tick();
      in_flush = 1'b0;
      tick();
      chk_word("t6_mid", 3'd1, 29'h501, 32'h20, 32'h0, 32'h0);
      rst = 1'b1;
      tick();
      chk("t6_rst_word", {out_wb_valid, out_wb_src, out_wb_id, out_wb_force_x, out_wb_force_y, out_wb_force_z}, '0);
      chk("t6_rst_flags", {out_flush_done, out_busy, err_overflow}, '0);
      rst = 1'b0;
      tick();
      tick();
      chk("t6_discarded", {out_wb_valid, out_busy, out_flush_done}, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
